// File: rtl/our_dmem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers it after
// LATENCY cycles from an internal array of 64-bit words.
module our_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam bit         DIRECT   = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        rsp_valid_q;
  logic [63:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        hold_write_q;
  logic [63:0] hold_addr_q;
  logic [63:0] hold_wdata_q;
  logic [1:0]  hold_size_q;
  logic        hold_unsigned_q;

  logic [63:0] mem_q [DEPTH_WORDS];

  logic             accept;
  logic             do_access;
  logic             mem_we;
  logic             a_write;
  logic [63:0]      a_addr;
  logic [63:0]      a_wdata;
  logic [1:0]       a_size;
  logic             a_unsigned;
  logic [IDX_W-1:0] idx;
  logic [2:0]       off;
  logic             err_d;
  logic [63:0]      old_word;
  logic [63:0]      bmask;
  logic [63:0]      wr_word_d;
  logic [63:0]      rdata_d;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] ofs);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << ofs;
  endfunction

  // Expand an 8-bit lane mask into a 64-bit bit mask.
  function automatic logic [63:0] expand_mask(input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] ofs);
    return ((size == 2'd1) && ofs[0]) ||
           ((size == 2'd2) && (ofs[1:0] != 2'd0)) ||
           ((size == 2'd3) && (ofs != 3'd0));
  endfunction

  // Right-justified raw bytes -> 64-bit load result with sign or zero extension.
  function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [1:0] size,
                                              input logic uns);
    case (size)
      2'd0:    return uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'd1:    return uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'd2:    return uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: return raw;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  // With LATENCY=1 the access happens on the accept edge itself, straight from the request bus.
  assign do_access = (DIRECT && (state_q == IDLE) && accept) ||
                     ((state_q == WAIT) && (cnt_q == 4'd1));
  // Reset gating keeps a held-low reset from committing a store on a clock edge.
  assign mem_we    = do_access && a_write && !err_d && reset;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Select the request source, check it, and form the store word and load result.
  always_comb begin
    a_write    = hold_write_q;
    a_addr     = hold_addr_q;
    a_wdata    = hold_wdata_q;
    a_size     = hold_size_q;
    a_unsigned = hold_unsigned_q;
    if (state_q == IDLE) begin
      a_write    = req_write;
      a_addr     = req_addr;
      a_wdata    = req_wdata;
      a_size     = req_size;
      a_unsigned = req_unsigned;
    end
    idx       = a_addr[IDX_W+2:3];
    off       = a_addr[2:0];
    err_d     = ((a_addr >> (IDX_W + 3)) != 64'd0) || misaligned(a_size, off);
    old_word  = mem_q[idx];
    bmask     = expand_mask(lane_mask(a_size, off));
    wr_word_d = (old_word & ~bmask) | ((a_wdata << {off, 3'b000}) & bmask);
    rdata_d   = 64'd0;
    if (!err_d && !a_write) rdata_d = load_extend(old_word >> {off, 3'b000}, a_size, a_unsigned);
  end

  // Capture the request fields on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_write_q    <= req_write;
      hold_addr_q     <= req_addr;
      hold_wdata_q    <= req_wdata;
      hold_size_q     <= req_size;
      hold_unsigned_q <= req_unsigned;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wr_word_d;
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (do_access) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rdata_d;
        rsp_err_q   <= err_d;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (DIRECT) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_our_dmem_responder.sv
// Bench for our_dmem_responder: a LATENCY=2 instance driven by directed and random
// transactions against a byte-array model, plus a LATENCY=1 instance for back-to-back timing.
module tb_our_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
  logic [63:0] b_req_addr, b_req_wdata;
  logic [1:0]  b_req_size;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [63:0] b_rsp_rdata;

  our_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  our_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size),
    .req_unsigned(b_req_unsigned),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]  ref_mem [DEPTH*8];
  int          acc1_q[$];
  int          rsp1_cyc_q[$];
  logic [63:0] rsp1_dat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor for the LATENCY=1 instance.
  always @(posedge clk) begin
    if (b_req_valid && b_req_ready) acc1_q.push_back(cyc);
    if (b_rsp_valid && b_rsp_ready) begin
      rsp1_cyc_q.push_back(cyc);
      rsp1_dat_q.push_back(b_rsp_rdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-addressed behavioural model of one access.
  function automatic void ref_access(input logic w, input logic [63:0] addr, input logic [63:0] wdata,
                                     input logic [1:0] size, input logic uns,
                                     output logic [63:0] rd, output logic er);
    int n = 1 << size;
    int base;
    rd = 64'd0;
    er = ((addr % 64'(n)) != 64'd0) || (addr >= 64'(DEPTH * 8));
    if (er) return;
    base = int'(addr);
    if (w) begin
      for (int i = 0; i < n; i++) ref_mem[base + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_mem[base + i];
      if (!uns && n < 8 && rd[8*n-1])
        for (int i = n; i < 8; i++) rd[8*i +: 8] = 8'hFF;
    end
  endfunction

  // One full transaction on the LATENCY=2 instance, with an optional response stall.
  task automatic txn(input string tag, input logic w, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [1:0] size, input logic uns, input int stall,
                     input logic [63:0] exp_rd, input logic exp_er);
    int n;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    rsp_ready    = (stall == 0);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, ":req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check({tag, ":latency"}, 64'(n), 64'(LAT));
    check({tag, ":rdata"}, rsp_rdata, exp_rd);
    check({tag, ":err"}, 64'(rsp_err), 64'(exp_er));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, ":stall_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, ":stall_rdata"}, rsp_rdata, exp_rd);
      check({tag, ":stall_err"}, 64'(rsp_err), 64'(exp_er));
      check({tag, ":stall_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, ":done_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, ":done_ready"}, 64'(req_ready), 64'd1);
    check({tag, ":done_rdata"}, rsp_rdata, 64'd0);
  endtask

  // Directed transaction: checks against the given values, keeps the model in step.
  task automatic dtxn(input string tag, input logic w, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [1:0] size, input logic uns, input int stall,
                      input logic [63:0] exp_rd, input logic exp_er);
    logic [63:0] rd;
    logic        er;
    ref_access(w, addr, wdata, size, uns, rd, er);
    txn(tag, w, addr, wdata, size, uns, stall, exp_rd, exp_er);
  endtask

  // Model-predicted transaction.
  task automatic mtxn(input string tag, input logic w, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [1:0] size, input logic uns, input int stall);
    logic [63:0] rd;
    logic        er;
    ref_access(w, addr, wdata, size, uns, rd, er);
    txn(tag, w, addr, wdata, size, uns, stall, rd, er);
  endtask

  // Single transaction on the LATENCY=1 instance.
  task automatic b_op(input logic w, input logic [63:0] addr, input logic [63:0] wdata);
    int na = acc1_q.size();
    int nr = rsp1_cyc_q.size();
    int k;
    @(negedge clk);
    b_req_valid    = 1'b1;
    b_req_write    = w;
    b_req_addr     = addr;
    b_req_wdata    = wdata;
    b_req_size     = 2'd3;
    b_req_unsigned = 1'b0;
    k = 0;
    while (acc1_q.size() == na && k < 20) begin @(negedge clk); k++; end
    b_req_valid = 1'b0;
    k = 0;
    while (rsp1_cyc_q.size() == nr && k < 20) begin @(negedge clk); k++; end
    check("b_op:rsp_seen", 64'(rsp1_cyc_q.size()), 64'(nr + 1));
  endtask

  initial begin
    int k;
    logic [1:0]  sz;
    logic [63:0] ad;

    reset          = 1'b0;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_addr       = 64'd0;
    req_wdata      = 64'd0;
    req_size       = 2'd0;
    req_unsigned   = 1'b0;
    rsp_ready      = 1'b1;
    b_req_valid    = 1'b0;
    b_req_write    = 1'b0;
    b_req_addr     = 64'd0;
    b_req_wdata    = 64'd0;
    b_req_size     = 2'd0;
    b_req_unsigned = 1'b0;
    b_rsp_ready    = 1'b1;

    repeat (2) @(negedge clk);
    check("reset:req_ready", 64'(req_ready), 64'd1);
    check("reset:rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset:rsp_rdata", rsp_rdata, 64'd0);
    check("reset:rsp_err", 64'(rsp_err), 64'd0);
    reset = 1'b1;

    dtxn("st_w0", 1, 64'h0, 64'hA5A5_0000_1234_5678, 2'd3, 0, 0, 64'd0, 0);
    dtxn("st_d10", 1, 64'h10, 64'h1122_3344_5566_7788, 2'd3, 0, 0, 64'd0, 0);
    dtxn("ld_d10", 0, 64'h10, 64'd0, 2'd3, 0, 0, 64'h1122_3344_5566_7788, 0);
    dtxn("st_b13", 1, 64'h13, 64'hDEAD_BEEF_0000_00F0, 2'd0, 0, 0, 64'd0, 0);
    dtxn("ld_b13s", 0, 64'h13, 64'd0, 2'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 0);
    dtxn("ld_b13u", 0, 64'h13, 64'd0, 2'd0, 1, 0, 64'h0000_0000_0000_00F0, 0);
    dtxn("ld_d10b", 0, 64'h10, 64'd0, 2'd3, 0, 0, 64'h1122_3344_F066_7788, 0);
    dtxn("ld_w12_mis", 0, 64'h12, 64'd0, 2'd2, 0, 0, 64'd0, 1);
    dtxn("st_h801_oor", 1, 64'h801, 64'hFFFF, 2'd1, 0, 0, 64'd0, 1);
    dtxn("ld_w0", 0, 64'h0, 64'd0, 2'd3, 0, 0, 64'hA5A5_0000_1234_5678, 0);
    dtxn("stall", 0, 64'h10, 64'd0, 2'd3, 0, 5, 64'h1122_3344_F066_7788, 0);

    // Store abandoned by reset while waiting.
    dtxn("st_d20", 1, 64'h20, 64'h0BAD_F00D_CAFE_BABE, 2'd3, 0, 0, 64'd0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = 64'h5555_5555_5555_5555;
    req_size  = 2'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid:busy", 64'(req_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("mid:req_ready", 64'(req_ready), 64'd1);
    check("mid:rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid:rsp_rdata", rsp_rdata, 64'd0);
    check("mid:rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dtxn("ld_d20", 0, 64'h20, 64'd0, 2'd3, 0, 0, 64'h0BAD_F00D_CAFE_BABE, 0);

    // Random traffic over a small initialised window plus occasional out-of-range addresses.
    for (int w = 0; w < 8; w++) mtxn("init", 1, 64'(w * 8), {$urandom, $urandom}, 2'd3, 0, 0);
    for (int t = 0; t < 40; t++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ad = {$urandom, $urandom} | 64'h800;
      else ad = 64'($urandom_range(0, 63));
      mtxn("rand", 1'($urandom_range(0, 1)), ad, {$urandom, $urandom}, sz,
           1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // LATENCY=1 instance: back-to-back loads with req_valid held high.
    b_op(1, 64'h0, 64'hC0C0_0000_0000_0001);
    b_op(1, 64'h8, 64'hC1C1_0000_0000_0002);
    acc1_q.delete();
    rsp1_cyc_q.delete();
    rsp1_dat_q.delete();
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_write = 1'b0;
    b_req_addr  = 64'h0;
    b_req_size  = 2'd3;
    k = 0;
    while (acc1_q.size() < 1 && k < 20) begin @(negedge clk); k++; end
    b_req_addr = 64'h8;
    k = 0;
    while (acc1_q.size() < 2 && k < 20) begin @(negedge clk); k++; end
    b_req_valid = 1'b0;
    k = 0;
    while (rsp1_cyc_q.size() < 2 && k < 20) begin @(negedge clk); k++; end
    check("b2b:acc_count", 64'(acc1_q.size()), 64'd2);
    check("b2b:rsp_count", 64'(rsp1_cyc_q.size()), 64'd2);
    if (acc1_q.size() >= 2 && rsp1_cyc_q.size() >= 2) begin
      check("b2b:accept_gap", 64'(acc1_q[1] - acc1_q[0]), 64'd2);
      check("b2b:lat0", 64'(rsp1_cyc_q[0] - acc1_q[0]), 64'd1);
      check("b2b:lat1", 64'(rsp1_cyc_q[1] - acc1_q[1]), 64'd1);
      check("b2b:data0", rsp1_dat_q[0], 64'hC0C0_0000_0000_0001);
      check("b2b:data1", rsp1_dat_q[1], 64'hC1C1_0000_0000_0002);
    end
    check("b2b:err", 64'(b_rsp_err), 64'd0);
    check("b2b:idle", 64'(b_req_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/our_dmem_responder.md
Name: our_dmem_responder

Overview:
- Responder side of the CPU data-memory interface: accepts one load or store request at a time over a valid/ready handshake.
- Performs the access into an internal 64-bit word array after a fixed, parameterised latency.
- Returns read data or an error status over a second valid/ready handshake.
- Replaces the zero-latency data memory so the core's load/store path can be exercised against multi-cycle memory timing.

Parameters:
- DEPTH_WORDS, 256, number of 64-bit words stored; must be a power of two.
- LATENCY, 2, cycles from request acceptance to rsp_valid assertion; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  64  byte address
- req_wdata  input  64  store data, right-justified
- req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts the response
- rsp_rdata  output  64  load result, extended to 64 bits; 0 for stores and errors
- rsp_err  output  1  misaligned or out-of-range access

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; latency counter=0.
  - Memory array contents are not reset.
- Request handshake:
  - Transfer occurs on a rising edge when req_valid && req_ready.
  - All req_* fields are captured into holding registers on that edge.
  - req_ready is 1 only in IDLE.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - On accept, go to WAIT with counter = LATENCY-1.
  - If LATENCY=1, go directly to RESP.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 1, go to RESP on the next edge.
  - Net effect: a request accepted at edge N produces rsp_valid=1 starting the cycle after edge N+LATENCY-1, i.e. visible for the first time exactly LATENCY cycles after acceptance.
- Access execution:
  - Performed on the edge that enters RESP; the memory write and the rsp_rdata/rsp_err registers update together.
  - Word index = addr[3+log2(DEPTH_WORDS)-1 : 3]; byte offset = addr[2:0].
- Error checks:
  - Misaligned: (size=1 and addr[0]) or (size=2 and addr[1:0]!=0) or (size=3 and addr[2:0]!=0).
  - Out-of-range: any of addr[63 : 3+log2(DEPTH_WORDS)] nonzero.
  - On error: rsp_err=1, rsp_rdata=0, no memory write.
- Store: only the byte lanes selected by size and offset are written from req_wdata's low bytes; other lanes keep their old value.
- Load:
  - Extract the selected bytes.
  - Sign-extend from the top selected bit when req_unsigned=0, zero-extend otherwise.
  - size=3 ignores req_unsigned.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable while rsp_ready=0 (no limit on stall length).
  - On an edge with rsp_ready=1: go to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - A new request can be accepted on the next edge at the earliest, so back-to-back throughput is one request per LATENCY+1 cycles.
- Request fields during WAIT and RESP: ignored. The requester must hold req_valid until it sees req_ready; a request presented during RESP is accepted once IDLE is reached.
- Reset mid-operation: the transaction is abandoned. A store that has not yet reached the RESP entry edge is not performed; a store already performed stays in memory.
- Unknown or unused encodings: none; all req_size values are legal.

Test Plan:
- Reset, then store size=3 addr=0x10 wdata=0x1122334455667788, rsp_ready=1 -> rsp_valid at exactly LATENCY=2 cycles after accept, rsp_err=0, rsp_rdata=0. Then load size=3 addr=0x10 -> rsp_rdata=0x1122334455667788.
- Store byte 0xF0 at addr=0x13, then load size=0 at 0x13:
  - signed load -> rsp_rdata=0xFFFFFFFFFFFFFFF0;
  - unsigned load -> 0x00000000000000F0;
  - load size=3 at 0x10 -> 0x11223344F0667788.
- Load size=2 addr=0x12 -> rsp_err=1, rsp_rdata=0. Store size=1 addr=0x801 (out of range, DEPTH_WORDS=256) -> rsp_err=1, and the word at index 0 is unchanged.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready=0; raise rsp_ready -> IDLE next cycle with req_ready=1.
- Assert reset low during WAIT of a store to 0x20 -> outputs take their reset values immediately and asynchronously; a later load of 0x20 returns the prior contents.
- LATENCY=1 build: two back-to-back loads with req_valid held high -> each response appears 1 cycle after its accept, and the second accept occurs 2 cycles after the first.
